ctrl_regs_mc: RTL and testbench
===============================

// Module: ctrl_regs_mc
// PURPOSE
//  Parametrised N-channel control/status register file for the MCDF datapath.
//  Decodes the cmd bus into per-channel R&W config registers (en/prio/pkglen) and R-only FIFO margin registers.
//  Adds a read-valid strobe, an illegal-access error strobe, and a sticky W1C "FIFO full" status register.
//  Its config outputs drive the slave channels and the arbiter; its margin inputs come from the slave FIFOs.
// PARAMETERS
//  CH_NUM      3     number of slave channels, 1..8
//  ADDR_W      8     cmd address width
//  DATA_W      32    cmd data width, >= 8
//  MARGIN_W    8     per-channel FIFO margin width
//  FIFO_DEPTH  32    margin reset value; must fit in MARGIN_W
//  RW_BASE     8'h00 channel n R&W reg at RW_BASE+4n
//  R_BASE      8'h10 channel n R reg at R_BASE+4n (read-only)
//  STAT_ADDR   8'h30 sticky status reg (R/W1C)
//  MASK_ADDR   8'h34 irq mask reg (exists only with MCDF_REG_IRQ_EN)
// PORTS
//  clk_i          in   1                 clock, rising edge
//  rstn_i         in   1                 reset, asynchronous, active-low
//  cmd_i          in   2                 2'b00 idle, 2'b10 write, 2'b01 read, 2'b11 treated as idle
//  cmd_addr_i     in   ADDR_W            byte address, word-aligned
//  cmd_data_i     in   DATA_W            write data
//  cmd_data_o     out  DATA_W            read data, registered
//  cmd_rvalid_o   out  1                 1-cycle pulse: cmd_data_o updated
//  cmd_err_o      out  1                 1-cycle pulse: illegal access
//  slv_margin_i   in   MARGIN_W*CH_NUM   ch n at [n*MARGIN_W +: MARGIN_W]
//  slv_en_o       out  CH_NUM            ch n enable
//  slv_prio_o     out  2*CH_NUM          ch n priority at [2n +: 2]
//  slv_pkglen_o   out  3*CH_NUM          ch n packet-length code at [3n +: 3]
//  irq_o          out  1                 registered interrupt, 0 without MCDF_REG_IRQ_EN
// BEHAVIOUR
//  Reset: all R&W regs = 0x07 (en=1, prio=3, pkglen=0); R regs = FIFO_DEPTH; status = 0; mask = 0;
//   cmd_data_o = 0; cmd_rvalid_o = 0; cmd_err_o = 0; irq_o = 0.
//  R&W reg layout: [0] en, [2:1] prio, [5:3] pkglen, [DATA_W-1:6] reserved (writes dropped, reads 0).
//  Write: takes effect at the clock edge sampling cmd_i=WRITE; outputs reflect it the next cycle. No write latency stall.
//  Read: cmd_data_o and cmd_rvalid_o appear exactly 1 cycle after cmd_i=READ. cmd_data_o holds its value until the next read.
//  R regs: each cycle sample {0, slv_margin_i[n]}; a read returns the value registered before the read edge.
//  Status reg: bit n sets on any cycle with slv_margin_i[n]==0 (FIFO full); stays set until written 1 at STAT_ADDR.
//   Writing 0 has no effect. Set and clear in the same cycle: set wins. Bits >= CH_NUM read 0.
//  Illegal access: cmd_err_o pulses 1 cycle after the command. Covers any unmapped address and any write to an R reg.
//   Illegal read: cmd_data_o <= 0 with cmd_rvalid_o=1. Illegal write: no state change.
//   Unaligned address (addr[1:0]!=0) is unmapped.
//  Back-to-back commands every cycle are supported. A read of a reg being written in the same cycle returns the old value.
//  cmd_i=2'b11: no action, no err.
//  Async reset mid-operation restores all reset values immediately; no pending rvalid/err survives.
// CONFIGURATION
//  MCDF_REG_IRQ_EN defined:
//   - MASK_ADDR is an R&W reg, bits [CH_NUM-1:0], upper bits read 0.
//   - irq_o <= |(status & mask), registered, so it rises 1 cycle after the status bit is visible.
//  MCDF_REG_IRQ_EN undefined:
//   - no mask reg; MASK_ADDR is unmapped (err on access).
//   - irq_o tied to 0.
// TESTING
//  T1 reset: after reset, read RW_BASE+0/4/8 -> 0x07 each with rvalid 1 cycle later; R_BASE+4 -> 0x20; slv_en_o=3'b111.
//  T2 write ch1 0xFFFF_FFFF -> read back 0x3F; slv_prio_o[3:2]=2'b11, slv_pkglen_o[5:3]=3'b111 next cycle.
//  T3 write 0x55 to R_BASE+8, read 0x40, read 0x02 -> cmd_err_o pulse on each; regs unchanged; reads return 0.
//  T4 drive ch2 margin 0 for 1 cycle, then 5 -> STAT reads 0x4. Write 0x4 while margin=0 -> stays 0x4. Clear with margin=5 -> 0x0.
//  T5 (IRQ_EN) mask=0x4, ch2 margin->0 -> irq_o=1 one cycle after STAT bit; W1C -> irq_o=0. Without IRQ_EN: read 0x34 -> err, irq_o stays 0.
//  T6 reset asserted the cycle after a READ -> cmd_rvalid_o stays 0, all outputs at reset values.

Source files
------------

// File: rtl/ctrl_regs_mc.sv
// ctrl_regs_mc: N-channel control/status register file for the MCDF datapath.
//
// Decodes the cmd bus into per-channel R&W config registers (en/prio/pkglen), read-only FIFO
// margin registers, a sticky W1C "FIFO full" status register and, optionally, an irq mask.
// Config outputs feed the slave channels and arbiter; margins come from the slave FIFOs.
//
// Optional feature macro: MCDF_REG_IRQ_EN (adds the mask register at MASK_ADDR and irq_o).
//
// Ports:
//   clk_i          clock, rising edge
//   rstn_i         asynchronous active-low reset
//   cmd_i          2'b10 write, 2'b01 read, 2'b00 / 2'b11 idle
//   cmd_addr_i     byte address (word aligned)
//   cmd_data_i     write data
//   cmd_data_o     registered read data, held until the next read
//   cmd_rvalid_o   1-cycle pulse, cmd_data_o updated
//   cmd_err_o      1-cycle pulse, illegal access
//   slv_margin_i   per-channel FIFO margin, ch n at [n*MARGIN_W +: MARGIN_W]
//   slv_en_o       per-channel enable
//   slv_prio_o     per-channel priority, ch n at [2n +: 2]
//   slv_pkglen_o   per-channel packet-length code, ch n at [3n +: 3]
//   irq_o          registered interrupt (0 without MCDF_REG_IRQ_EN)
module ctrl_regs_mc #(
  parameter int unsigned         CH_NUM     = 3,
  parameter int unsigned         ADDR_W     = 8,
  parameter int unsigned         DATA_W     = 32,
  parameter int unsigned         MARGIN_W   = 8,
  parameter int unsigned         FIFO_DEPTH = 32,
  parameter logic [ADDR_W-1:0]   RW_BASE    = 'h00,
  parameter logic [ADDR_W-1:0]   R_BASE     = 'h10,
  parameter logic [ADDR_W-1:0]   STAT_ADDR  = 'h30,
  parameter logic [ADDR_W-1:0]   MASK_ADDR  = 'h34
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [1:0]                   cmd_i,
  input  logic [ADDR_W-1:0]            cmd_addr_i,
  input  logic [DATA_W-1:0]            cmd_data_i,
  output logic [DATA_W-1:0]            cmd_data_o,
  output logic                         cmd_rvalid_o,
  output logic                         cmd_err_o,
  input  logic [MARGIN_W*CH_NUM-1:0]   slv_margin_i,
  output logic [CH_NUM-1:0]            slv_en_o,
  output logic [2*CH_NUM-1:0]          slv_prio_o,
  output logic [3*CH_NUM-1:0]          slv_pkglen_o,
  output logic                         irq_o
);

  localparam logic [5:0] CfgRst = 6'h07;

  logic [5:0]          cfg_q    [CH_NUM];
  logic [5:0]          cfg_d    [CH_NUM];
  logic [MARGIN_W-1:0] margin_q [CH_NUM];
  logic [CH_NUM-1:0]   stat_q, stat_d, stat_set, stat_clr;
  logic [DATA_W-1:0]   rdata_q, rdata_d, rd_val;
  logic                rvalid_q, rvalid_d, err_q, err_d;
  logic                is_wr, is_rd, legal;
`ifdef MCDF_REG_IRQ_EN
  logic [CH_NUM-1:0]   mask_q, mask_d;
  logic                irq_q;
`endif

  // Upper write-data bits land only in reserved fields.
  logic unused_data;
  assign unused_data = ^cmd_data_i;

  always_comb begin
    is_wr    = (cmd_i == 2'b10);
    is_rd    = (cmd_i == 2'b01);
    cfg_d    = cfg_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    legal    = 1'b0;
    rd_val   = '0;
    stat_clr = '0;
    stat_set = '0;
`ifdef MCDF_REG_IRQ_EN
    mask_d   = mask_q;
`endif

    if (cmd_addr_i[1:0] == 2'b00) begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (cmd_addr_i == RW_BASE + ADDR_W'(4 * n)) begin
          legal  = 1'b1;
          rd_val = DATA_W'(cfg_q[n]);
          if (is_wr) cfg_d[n] = cmd_data_i[5:0];
        end
        // Margin registers are read-only: a write there is illegal.
        if (cmd_addr_i == R_BASE + ADDR_W'(4 * n)) begin
          legal  = is_rd;
          rd_val = DATA_W'(margin_q[n]);
        end
      end
      if (cmd_addr_i == STAT_ADDR) begin
        legal  = 1'b1;
        rd_val = DATA_W'(stat_q);
        if (is_wr) stat_clr = cmd_data_i[CH_NUM-1:0];
      end
`ifdef MCDF_REG_IRQ_EN
      if (cmd_addr_i == MASK_ADDR) begin
        legal  = 1'b1;
        rd_val = DATA_W'(mask_q);
        if (is_wr) mask_d = cmd_data_i[CH_NUM-1:0];
      end
`endif
    end

    if (is_rd) begin
      rvalid_d = 1'b1;
      rdata_d  = legal ? rd_val : '0;
      err_d    = ~legal;
    end else if (is_wr) begin
      err_d    = ~legal;
    end

    // A FIFO-full event in the same cycle as a W1C keeps the bit set.
    for (int n = 0; n < CH_NUM; n++) begin
      stat_set[n] = (slv_margin_i[n*MARGIN_W +: MARGIN_W] == '0);
    end
    stat_d = (stat_q & ~stat_clr) | stat_set;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int n = 0; n < CH_NUM; n++) begin
        cfg_q[n]    <= CfgRst;
        margin_q[n] <= MARGIN_W'(FIFO_DEPTH);
      end
      stat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef MCDF_REG_IRQ_EN
      mask_q   <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      for (int n = 0; n < CH_NUM; n++) begin
        cfg_q[n]    <= cfg_d[n];
        margin_q[n] <= slv_margin_i[n*MARGIN_W +: MARGIN_W];
      end
      stat_q   <= stat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
`ifdef MCDF_REG_IRQ_EN
      mask_q   <= mask_d;
      irq_q    <= |(stat_q & mask_q);
`endif
    end
  end

  always_comb begin
    for (int n = 0; n < CH_NUM; n++) begin
      slv_en_o[n]           = cfg_q[n][0];
      slv_prio_o[2*n +: 2]  = cfg_q[n][2:1];
      slv_pkglen_o[3*n +: 3] = cfg_q[n][5:3];
    end
  end

  assign cmd_data_o   = rdata_q;
  assign cmd_rvalid_o = rvalid_q;
  assign cmd_err_o    = err_q;
`ifdef MCDF_REG_IRQ_EN
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_regs_mc.sv
module tb_ctrl_regs_mc;

  typedef struct packed {
    logic        rv;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rstn  = 1'b1;
  logic [1:0]  cmd   = 2'b00;
  logic [7:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, err, irq;
  logic [23:0] margin = {3{8'd32}};
  logic [2:0]  en;
  logic [5:0]  prio;
  logic [8:0]  pkglen;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  ctrl_regs_mc dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn),
    .cmd_i        (cmd),
    .cmd_addr_i   (addr),
    .cmd_data_i   (wdata),
    .cmd_data_o   (rdata),
    .cmd_rvalid_o (rvalid),
    .cmd_err_o    (err),
    .slv_margin_i (margin),
    .slv_en_o     (en),
    .slv_prio_o   (prio),
    .slv_pkglen_o (pkglen),
    .irq_o        (irq)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rvalid === 1'b1 || err === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp rvalid=%0b err=%0b data=%h (none expected)",
                 rvalid, err, rdata);
      end else begin
        e = exp_q.pop_front();
        if (rvalid !== e.rv || err !== e.err || (e.chk && rdata !== e.data)) begin
          errors++;
          $display("FAIL resp got rvalid=%0b err=%0b data=%h need rvalid=%0b err=%0b data=%h",
                   rvalid, err, rdata, e.rv, e.err, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h need %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cmd = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input logic exp_err);
    cmd  = 2'b01;
    addr = a;
    exp_q.push_back('{rv: 1'b1, err: exp_err, chk: 1'b1, data: exp});
    step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic exp_err);
    cmd   = 2'b10;
    addr  = a;
    wdata = d;
    if (exp_err) exp_q.push_back('{rv: 1'b0, err: 1'b1, chk: 1'b0, data: '0});
    step();
  endtask

  initial begin
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    // Reset values
    check("rst_en", 32'(en), 32'h7);
    check("rst_prio", 32'(prio), 32'h3F);
    check("rst_pkglen", 32'(pkglen), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rstn = 1'b1;
    idle(1);

    // T1: reset register contents
    rd(8'h00, 32'h07, 1'b0);
    rd(8'h04, 32'h07, 1'b0);
    rd(8'h08, 32'h07, 1'b0);
    rd(8'h14, 32'h20, 1'b0);
    rd(8'h30, 32'h00, 1'b0);

    // T2: reserved bits dropped; outputs follow the next cycle
    wr(8'h04, 32'hFFFF_FFFF, 1'b0);
    check("t2_prio1", 32'(prio[3:2]), 32'h3);
    check("t2_pkglen1", 32'(pkglen[5:3]), 32'h7);
    check("t2_en", 32'(en), 32'h7);
    rd(8'h04, 32'h3F, 1'b0);
    // Back-to-back write then read of ch0, en cleared
    wr(8'h00, 32'h0000_002A, 1'b0);
    rd(8'h00, 32'h2A, 1'b0);
    check("b2b_en", 32'(en), 32'h6);
    check("b2b_pkglen0", 32'(pkglen[2:0]), 32'h5);

    // T3: illegal accesses
    wr(8'h18, 32'h55, 1'b1);
    rd(8'h40, 32'h0, 1'b1);
    rd(8'h02, 32'h0, 1'b1);
    rd(8'h18, 32'h20, 1'b0);
    rd(8'h04, 32'h3F, 1'b0);
    wr(8'h05, 32'h00, 1'b1);
    rd(8'h04, 32'h3F, 1'b0);
    // cmd 2'b11 produces no response
    cmd  = 2'b11;
    addr = 8'h00;
    step();
    idle(2);

    // T4: sticky W1C status, set wins over clear
    margin[23:16] = 8'd0;
    idle(1);
    margin[23:16] = 8'd5;
    rd(8'h30, 32'h4, 1'b0);
    margin[23:16] = 8'd0;
    wr(8'h30, 32'h4, 1'b0);
    margin[23:16] = 8'd5;
    rd(8'h30, 32'h4, 1'b0);
    rd(8'h18, 32'h5, 1'b0);
    wr(8'h30, 32'h0, 1'b0);
    rd(8'h30, 32'h4, 1'b0);
    wr(8'h30, 32'h4, 1'b0);
    rd(8'h30, 32'h0, 1'b0);

    // T5: interrupt
`ifdef MCDF_REG_IRQ_EN
    wr(8'h34, 32'hFF, 1'b0);
    rd(8'h34, 32'h7, 1'b0);
    wr(8'h34, 32'h4, 1'b0);
    margin[23:16] = 8'd0;
    idle(1);
    margin[23:16] = 8'd5;
    check("irq_lag", 32'(irq), 32'h0);
    idle(1);
    check("irq_set", 32'(irq), 32'h1);
    wr(8'h30, 32'h4, 1'b0);
    check("irq_hold", 32'(irq), 32'h1);
    idle(1);
    check("irq_clr", 32'(irq), 32'h0);
`else
    rd(8'h34, 32'h0, 1'b1);
    wr(8'h34, 32'h4, 1'b1);
    margin[23:16] = 8'd0;
    idle(1);
    margin[23:16] = 8'd5;
    idle(1);
    check("irq_off", 32'(irq), 32'h0);
    wr(8'h30, 32'h4, 1'b0);
`endif

    // T6: reset right after a read is sampled
    idle(2);
    cmd  = 2'b01;
    addr = 8'h04;
    @(posedge clk_i);
    #1;
    rstn = 1'b0;
    cmd  = 2'b00;
    #1;
    check("t6_rvalid", 32'(rvalid), 32'h0);
    check("t6_err", 32'(err), 32'h0);
    check("t6_rdata", rdata, 32'h0);
    check("t6_en", 32'(en), 32'h7);
    check("t6_prio", 32'(prio), 32'h3F);
    check("t6_pkglen", 32'(pkglen), 32'h0);
    check("t6_irq", 32'(irq), 32'h0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    rd(8'h04, 32'h07, 1'b0);
    rd(8'h30, 32'h00, 1'b0);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_resp outstanding %0d need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
